im_responder: RTL and testbench

IM_RESPONDER -- requirements
Module: im_responder

---
 rtl/im_responder_pkg.sv | 21 ++
 rtl/im_responder_if.sv | 24 ++
 rtl/im_wait_counter.sv | 37 +++
 rtl/im_responder.sv | 136 +++++++++++++
 tb/tb_im_responder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/im_responder_pkg.sv
// Shared types and constants for the instruction-memory responder and its wait counter.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package im_responder_pkg;

  localparam int unsigned DataW           = `DATA_SIZE;
  localparam int unsigned MemAw           = 14;
  localparam int unsigned FirstLatDefault = 3;
  localparam int unsigned SeqLatDefault   = 1;
  localparam int unsigned CntW            = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StCap,
    StHold
  } state_e;

endpackage

// File: rtl/im_responder_if.sv
// Fetch-side handshake plus SRAM macro pins; slave is the responder, master the environment.
interface im_responder_if;
  import im_responder_pkg::*;

  logic             IM_enable;
  logic [31:0]      IM_address;
  logic             ready;
  logic [DataW-1:0] IM_rdata;
  logic             mem_CS;
  logic             mem_OE;
  logic [MemAw-1:0] mem_A;
  logic [DataW-1:0] mem_DO;

  modport master (
    output IM_enable, IM_address, mem_DO,
    input  ready, IM_rdata, mem_CS, mem_OE, mem_A
  );

  modport slave (
    input  IM_enable, IM_address, mem_DO,
    output ready, IM_rdata, mem_CS, mem_OE, mem_A
  );

endinterface

// File: rtl/im_wait_counter.sv
// Loadable down-counter timing the wait before the SRAM strobe; saturates at zero.
module im_wait_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             zero_next_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o      = (cnt_q == '0);
  // Lets the owner register a strobe that lines up with the zero cycle.
  assign zero_next_o = (cnt_d == '0);

endmodule

// File: rtl/im_responder.sv
// Instruction-memory responder: serves I-cache word fetches from a single-port SRAM macro.
module im_responder
  import im_responder_pkg::*;
#(
  parameter int unsigned FIRST_LAT = FirstLatDefault,
  parameter int unsigned SEQ_LAT   = SeqLatDefault
) (
  input logic           clk,
  input logic           rst,
  im_responder_if.slave bus
);

  if ((FIRST_LAT < 1) || (FIRST_LAT > 15)) begin : g_bad_first_lat
    $error("FIRST_LAT must be in 1..15");
  end
  if ((SEQ_LAT < 1) || (SEQ_LAT > 15)) begin : g_bad_seq_lat
    $error("SEQ_LAT must be in 1..15");
  end

  localparam logic [CntW-1:0] FirstLoad = CntW'(FIRST_LAT - 1);
  localparam logic [CntW-1:0] SeqLoad   = CntW'(SEQ_LAT - 1);

  state_e           state_q, state_d;
  logic [29:0]      req_word_q, req_word_d;
  logic [27:0]      last_line_q, last_line_d;
  logic             line_valid_q, line_valid_d;
  logic [DataW-1:0] rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             cs_q, cs_d;

  logic            start, cnt_dec, cnt_zero, cnt_zero_next;
  logic            word_same, line_hit;
  logic [CntW-1:0] cnt_load_val;
  logic            unused_addr_lsb;

  assign unused_addr_lsb = ^bus.IM_address[1:0];

  assign word_same    = (bus.IM_address[31:2] == req_word_q);
  // Upper address bits alias in the SRAM but still distinguish lines here.
  assign line_hit     = line_valid_q && (bus.IM_address[31:4] == last_line_q);
  assign cnt_load_val = line_hit ? SeqLoad : FirstLoad;

  always_comb begin
    state_d      = state_q;
    req_word_d   = req_word_q;
    last_line_d  = last_line_q;
    line_valid_d = line_valid_q;
    rdata_d      = rdata_q;
    start        = 1'b0;
    cnt_dec      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.IM_enable) start = 1'b1;
      end
      StWait: begin
        if (!bus.IM_enable) begin
          state_d = StIdle;
        end else if (!word_same) begin
          start = 1'b1;
        end else if (cnt_zero) begin
          state_d = StCap;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StCap: begin
        if (!bus.IM_enable) begin
          state_d = StIdle;
        end else if (!word_same) begin
          start = 1'b1;
        end else begin
          rdata_d      = bus.mem_DO;
          last_line_d  = req_word_q[29:2];
          line_valid_d = 1'b1;
          state_d      = StHold;
        end
      end
      StHold: begin
        if (!bus.IM_enable) begin
          state_d = StIdle;
        end else if (!word_same) begin
          start = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d    = StWait;
      req_word_d = bus.IM_address[31:2];
    end
  end

  assign ready_d = (state_d == StHold);
  assign cs_d    = (state_d == StWait) && cnt_zero_next;

  im_wait_counter #(
    .Width (CntW)
  ) u_wait_counter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (start),
    .load_val_i  (cnt_load_val),
    .dec_i       (cnt_dec),
    .zero_o      (cnt_zero),
    .zero_next_o (cnt_zero_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      req_word_q   <= '0;
      last_line_q  <= '0;
      line_valid_q <= 1'b0;
      rdata_q      <= '0;
      ready_q      <= 1'b0;
      cs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_word_q   <= req_word_d;
      last_line_q  <= last_line_d;
      line_valid_q <= line_valid_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
      cs_q         <= cs_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.IM_rdata = rdata_q;
  assign bus.mem_CS   = cs_q;
  assign bus.mem_OE   = cs_q;
  assign bus.mem_A    = req_word_q[MemAw-1:0];

endmodule

// File: tb/tb_im_responder.sv
// Self-checking bench for im_responder: directed latency table, corner sequences, random vs model.
module tb_im_responder;

  localparam int FirstLat = 3;
  localparam int SeqLat   = 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  im_responder_if bus ();

  im_responder #(
    .FIRST_LAT (FirstLat),
    .SEQ_LAT   (SeqLat)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [13:0] a);
    if (a == 14'h040) return 32'hDEAD_BEEF;
    return {a, 18'h0} ^ {18'h0, a} ^ 32'h1357_9BDF;
  endfunction

  // Synchronous SRAM: data only valid in the cycle after a strobe.
  always @(posedge clk) begin
    bus.mem_DO <= bus.mem_CS ? data_of(bus.mem_A) : 32'h0BAD_F00D;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.IM_enable  = 1'b0;
    bus.IM_address = '0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Called at the sample point of cycle 0; returns at the sample point of the ready cycle.
  task automatic run_req(input logic [31:0] addr, output int s_cyc, output int r_cyc,
                         output int s_cnt, output logic [13:0] s_a, output logic [31:0] rd);
    s_cyc = -1;
    r_cyc = -1;
    s_cnt = 0;
    s_a   = '0;
    rd    = '0;
    bus.IM_enable  = 1'b1;
    bus.IM_address = addr;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.mem_CS) begin
        if (s_cnt == 0) begin
          s_cyc = c;
          s_a   = bus.mem_A;
        end
        s_cnt++;
      end
      if (bus.ready) begin
        r_cyc = c;
        rd    = bus.IM_rdata;
        break;
      end
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          s_cyc;
    int          r_cyc;
    logic [13:0] a;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[7];

  // Transaction-level reference: a request's age since first sampling decides every output.
  bit          m_act;
  logic [29:0] m_word;
  int          m_age;
  int          m_lat;
  logic [27:0] m_line;
  bit          m_lv;
  logic [31:0] m_rd;

  task automatic model_reset();
    m_act  = 1'b0;
    m_word = '0;
    m_age  = 0;
    m_lat  = FirstLat;
    m_line = '0;
    m_lv   = 1'b0;
    m_rd   = '0;
  endtask

  task automatic model_step(input logic en, input logic [31:0] addr);
    if (m_act && !en) begin
      m_act = 1'b0;
    end else if (en && (!m_act || addr[31:2] != m_word)) begin
      m_lat  = (m_lv && addr[31:4] == m_line) ? SeqLat : FirstLat;
      m_word = addr[31:2];
      m_act  = 1'b1;
      m_age  = 1;
    end else if (m_act) begin
      if (m_age == m_lat + 1) begin
        m_rd   = data_of(m_word[13:0]);
        m_line = m_word[29:2];
        m_lv   = 1'b1;
      end
      if (m_age < m_lat + 2) m_age++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s_cyc, r_cyc, s_cnt, n_cs, n_rdy;
    logic [13:0] s_a;
    logic [31:0] rd, held;
    logic        en;
    logic [31:0] addr;
    logic [48:0] exp_v, act_v;

    checks = 0;
    errors = 0;

    vecs[0] = '{32'h0000_0100, FirstLat, FirstLat + 2, 14'h040, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0104, SeqLat, SeqLat + 2, 14'h041, data_of(14'h041)};
    vecs[2] = '{32'h0000_0108, SeqLat, SeqLat + 2, 14'h042, data_of(14'h042)};
    vecs[3] = '{32'h0000_010C, SeqLat, SeqLat + 2, 14'h043, data_of(14'h043)};
    vecs[4] = '{32'h0001_0100, FirstLat, FirstLat + 2, 14'h040, 32'hDEAD_BEEF};
    vecs[5] = '{32'h0000_0110, FirstLat, FirstLat + 2, 14'h044, data_of(14'h044)};
    vecs[6] = '{32'h0000_0114, SeqLat, SeqLat + 2, 14'h045, data_of(14'h045)};

    rst            = 1'b0;
    bus.IM_enable  = 1'b0;
    bus.IM_address = '0;
    #2 rst = 1'b1;
    #2;
    chk("reset_ready", 64'(bus.ready), 64'd0);
    chk("reset_rdata", 64'(bus.IM_rdata), 64'd0);
    chk("reset_cs", 64'(bus.mem_CS), 64'd0);
    chk("reset_oe", 64'(bus.mem_OE), 64'd0);
    chk("reset_mem_a", 64'(bus.mem_A), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Line fill, alias and line-change table.
    for (int i = 0; i < 7; i++) begin
      run_req(vecs[i].addr, s_cyc, r_cyc, s_cnt, s_a, rd);
      chk($sformatf("v%0d_strobe_cycle", i), 64'(s_cyc), 64'(vecs[i].s_cyc));
      chk($sformatf("v%0d_ready_cycle", i), 64'(r_cyc), 64'(vecs[i].r_cyc));
      chk($sformatf("v%0d_strobe_count", i), 64'(s_cnt), 64'd1);
      chk($sformatf("v%0d_mem_a", i), 64'(s_a), 64'(vecs[i].a));
      chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].rd));
      if (i < 6) tick();
    end

    // Requester stall: ready and data hold, no new strobe.
    held = vecs[6].rd;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("stall%0d_ready", k), 64'(bus.ready), 64'd1);
      chk($sformatf("stall%0d_rdata", k), 64'(bus.IM_rdata), 64'(held));
      chk($sformatf("stall%0d_cs", k), 64'(bus.mem_CS), 64'd0);
    end

    // Abort in cycle 2 of a first access, then next request still pays FIRST_LAT.
    do_reset();
    bus.IM_enable  = 1'b1;
    bus.IM_address = 32'h0000_0100;
    tick();
    tick();
    bus.IM_enable = 1'b0;
    n_cs  = 0;
    n_rdy = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.mem_CS) n_cs++;
      if (bus.ready) n_rdy++;
    end
    chk("abort_strobes", 64'(n_cs), 64'd0);
    chk("abort_ready", 64'(n_rdy), 64'd0);
    chk("abort_rdata", 64'(bus.IM_rdata), 64'd0);
    run_req(32'h0000_0104, s_cyc, r_cyc, s_cnt, s_a, rd);
    chk("after_abort_strobe_cycle", 64'(s_cyc), 64'(FirstLat));
    chk("after_abort_ready_cycle", 64'(r_cyc), 64'(FirstLat + 2));

    // Reset pulsed during a sequential access's strobe cycle.
    tick();
    bus.IM_address = 32'h0000_0108;
    tick();
    chk("pre_reset_strobe", 64'(bus.mem_CS), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    act_v = {bus.ready, bus.mem_CS, bus.mem_OE, bus.mem_A, bus.IM_rdata};
    chk("mid_reset_outputs", 64'(act_v), 64'd0);
    bus.IM_enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_req(32'h0000_0100, s_cyc, r_cyc, s_cnt, s_a, rd);
    chk("post_reset_strobe_cycle", 64'(s_cyc), 64'(FirstLat));
    chk("post_reset_ready_cycle", 64'(r_cyc), 64'(FirstLat + 2));
    chk("post_reset_rdata", 64'(rd), 64'h0000_0000_DEAD_BEEF);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    en   = 1'b0;
    addr = '0;
    for (int n = 0; n < 1500; n++) begin
      exp_v = {(m_act && m_age >= m_lat + 2), (m_act && m_age == m_lat),
               (m_act && m_age == m_lat), m_word[13:0], m_rd};
      act_v = {bus.ready, bus.mem_CS, bus.mem_OE, bus.mem_A, bus.IM_rdata};
      chk($sformatf("rand_cycle%0d", n), 64'(act_v), 64'(exp_v));
      if ($urandom_range(0, 99) < 15) begin
        en   = ($urandom_range(0, 3) != 0);
        addr = {15'b0, 1'($urandom_range(0, 1)), 10'h0, 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      end
      bus.IM_enable  = en;
      bus.IM_address = addr;
      model_step(en, addr);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
